// File: rtl/kbd_pkg.sv
// ---------------------------------------------------------------------------
// kbd_pkg
// Shared definitions for the keyboard event stage:
//   - kbd_state_e : scan-code prefix parser states
//   - SC_*        : prefix bytes and the controller response bytes that are
//                   never treated as key codes
//   - kbd_evt_t   : decoded event word {ext, brk, code} as queued in the FIFO
//   - BLANK_SEG   : active-low pattern with every segment off
// ---------------------------------------------------------------------------
package kbd_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        E0   = 2'd1,
        F0   = 2'd2,
        E0F0 = 2'd3
    } kbd_state_e;

    localparam logic [7:0] SC_EXT = 8'hE0;   // extended-key prefix
    localparam logic [7:0] SC_BRK = 8'hF0;   // break (release) prefix

    // Keyboard responses that share the byte stream with scan codes.
    localparam logic [7:0] SC_ACK  = 8'hFA;  // command acknowledge
    localparam logic [7:0] SC_BAT  = 8'hAA;  // self-test passed
    localparam logic [7:0] SC_ERR0 = 8'h00;  // key detection error / overrun
    localparam logic [7:0] SC_ERR1 = 8'hFF;  // key detection error / overrun

    localparam int EVT_W = 10;

    typedef struct packed {
        logic       ext;
        logic       brk;
        logic [7:0] code;
    } kbd_evt_t;

    localparam logic [7:0] BLANK_SEG = 8'hFF;

    // True for bytes that are swallowed when no prefix is pending.
    function automatic logic is_dropped(input logic [7:0] b);
        return (b == SC_ACK) || (b == SC_BAT) || (b == SC_ERR0) || (b == SC_ERR1);
    endfunction

endpackage

// File: rtl/kbd_event_tracker_if.sv
// ---------------------------------------------------------------------------
// kbd_event_tracker_if
// Byte-in / event-out bundle of the keyboard event stage.
//   byte_valid, byte_data : one-cycle strobe and scan-code byte from the
//                           PS/2 receiver
//   evt_valid, evt_data   : FIFO head, first-word fall-through
//   evt_ready             : consumer accepts the head when evt_valid
// Modports:
//   slave  : the tracker (consumes bytes, produces events)
//   master : the surrounding logic (produces bytes, consumes events)
// ---------------------------------------------------------------------------
interface kbd_event_tracker_if;
    import kbd_pkg::*;

    logic             byte_valid;
    logic [7:0]       byte_data;
    logic             evt_valid;
    logic             evt_ready;
    logic [EVT_W-1:0] evt_data;

    modport slave (
        input  byte_valid,
        input  byte_data,
        input  evt_ready,
        output evt_valid,
        output evt_data
    );

    modport master (
        output byte_valid,
        output byte_data,
        output evt_ready,
        input  evt_valid,
        input  evt_data
    );

endinterface

// File: rtl/hex7seg.sv
// ---------------------------------------------------------------------------
// hex7seg
// Hex nibble to active-low seven-segment pattern, segment order
// {dp, g, f, e, d, c, b, a}; the decimal point is always off.
//   nibble : value to show (0..F)
//   seg    : active-low segment drive
// ---------------------------------------------------------------------------
module hex7seg (
    input  logic [3:0] nibble,
    output logic [7:0] seg
);

    // NOTE: a combinational block must assign its outputs on every path
    // (here the default arm) or synthesis infers a latch.
    always_comb begin
        case (nibble)
            4'h0:    seg = 8'hC0;
            4'h1:    seg = 8'hF9;
            4'h2:    seg = 8'hA4;
            4'h3:    seg = 8'hB0;
            4'h4:    seg = 8'h99;
            4'h5:    seg = 8'h92;
            4'h6:    seg = 8'h82;
            4'h7:    seg = 8'hF8;
            4'h8:    seg = 8'h80;
            4'h9:    seg = 8'h90;
            4'hA:    seg = 8'h88;
            4'hB:    seg = 8'h83;
            4'hC:    seg = 8'hC6;
            4'hD:    seg = 8'hA1;
            4'hE:    seg = 8'h86;
            default: seg = 8'h8E;
        endcase
    end

endmodule

// File: rtl/kbd_evt_fifo.sv
// ---------------------------------------------------------------------------
// kbd_evt_fifo
// Synchronous first-word fall-through FIFO for decoded key events.
// A push while full is accepted only if a pop happens in the same cycle;
// otherwise it is dropped and reported on 'drop' for that cycle.
//   clk, rst  : clock, asynchronous active-low reset
//   push      : push_data is to be queued this cycle
//   push_data : event word
//   pop       : consumer takes the head (ignored while empty)
//   head      : current head entry (meaningful when not_empty)
//   not_empty : at least one entry queued
//   drop      : the push of this cycle was lost because the FIFO was full
// ---------------------------------------------------------------------------
module kbd_evt_fifo #(
    parameter int DEPTH = 8,   // power of 2, >= 2
    parameter int WIDTH = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             not_empty,
    output logic             drop
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      level;
    logic             full;
    logic             do_pop;
    logic             do_push;

    assign full      = (level == (AW+1)'(DEPTH));
    assign not_empty = (level != '0);
    assign do_pop    = pop && not_empty;
    // A pop in the same cycle frees the slot the push needs.
    assign do_push   = push && (!full || do_pop);
    assign drop      = push && full && !do_pop;
    assign head      = mem[rd_ptr];

    // NOTE: registered state is written with non-blocking assignments so
    // every flop samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

    // NOTE: storage is not reset; the pointers and level define which
    // entries are live, so clearing the array would only cost reset fan-out.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/kbd_event_tracker.sv
// ---------------------------------------------------------------------------
// kbd_event_tracker
// Keyboard event stage between the PS/2 byte receiver and the display bank.
// Parses make / break (F0) / extended (E0) scan-code sequences, keeps a small
// table of held keys to suppress typematic repeats, counts distinct presses
// and queues decoded events for a downstream consumer.
//   clk, rst     : clock, asynchronous active-low reset
//   bus          : byte input and event output handshake (slave modport)
//   evt_overflow : sticky, an event was dropped because the FIFO was full
//   key_code     : code of the last accepted make
//   key_ext      : extended flag of the last accepted make
//   is_press     : at least one key held in the table
//   press_count  : number of distinct presses, wraps
//   key_seg      : {hi, lo} active-low digits of key_code, blank when idle
//   count_seg    : active-low digits of press_count, MS digit in MSBs
// ---------------------------------------------------------------------------
module kbd_event_tracker
    import kbd_pkg::*;
#(
    parameter int HELD_DEPTH = 4,   // 1..8 simultaneously held keys
    parameter int FIFO_DEPTH = 8,   // power of 2, >= 2
    parameter int CNT_W      = 8    // multiple of 4
) (
    input  logic                 clk,
    input  logic                 rst,
    kbd_event_tracker_if.slave   bus,
    output logic                 evt_overflow,
    output logic [7:0]           key_code,
    output logic                 key_ext,
    output logic                 is_press,
    output logic [CNT_W-1:0]     press_count,
    output logic [15:0]          key_seg,
    output logic [2*CNT_W-1:0]   count_seg
);

    localparam int DIGITS = CNT_W / 4;

    // -----------------------------------------------------------------------
    // Prefix parser
    // -----------------------------------------------------------------------
    kbd_state_e state;
    kbd_state_e state_nxt;
    logic       gen_make;
    logic       gen_brk;
    logic       gen_ext;

    always_comb begin
        state_nxt = state;
        gen_make  = 1'b0;
        gen_brk   = 1'b0;
        gen_ext   = 1'b0;
        if (bus.byte_valid) begin
            case (state)
                IDLE: begin
                    if (bus.byte_data == SC_EXT)
                        state_nxt = E0;
                    else if (bus.byte_data == SC_BRK)
                        state_nxt = F0;
                    else if (!is_dropped(bus.byte_data))
                        gen_make = 1'b1;
                end
                E0: begin
                    if (bus.byte_data == SC_BRK) begin
                        state_nxt = E0F0;
                    end else if (bus.byte_data == SC_EXT) begin
                        state_nxt = E0;
                    end else begin
                        gen_make  = 1'b1;
                        gen_ext   = 1'b1;
                        state_nxt = IDLE;
                    end
                end
                F0: begin
                    gen_brk   = 1'b1;
                    state_nxt = IDLE;
                end
                E0F0: begin
                    gen_brk   = 1'b1;
                    gen_ext   = 1'b1;
                    state_nxt = IDLE;
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    // -----------------------------------------------------------------------
    // Held-key table
    // -----------------------------------------------------------------------
    logic [HELD_DEPTH-1:0] slot_valid;
    logic [8:0]            slot_key [HELD_DEPTH];
    logic [8:0]            cur_key;
    logic [HELD_DEPTH-1:0] slot_hit;
    logic [HELD_DEPTH-1:0] free_onehot;
    logic                  hit;
    logic                  new_press;

    assign cur_key = {gen_ext, bus.byte_data};

    always_comb begin
        for (int i = 0; i < HELD_DEPTH; i++)
            slot_hit[i] = slot_valid[i] && (slot_key[i] == cur_key);
    end

    assign hit = |slot_hit;
    // Lowest clear bit of slot_valid as a one-hot; zero when the table is full.
    assign free_onehot = ~slot_valid & (slot_valid + 1'b1);
    // A make of a key already held is a typematic repeat and is ignored.
    assign new_press = gen_make && !hit;

    // -----------------------------------------------------------------------
    // Event FIFO
    // -----------------------------------------------------------------------
    kbd_evt_t push_evt;
    logic     fifo_push;
    logic     fifo_drop;
    logic     fifo_not_empty;

    always_comb begin
        push_evt.ext  = gen_ext;
        push_evt.brk  = gen_brk;
        push_evt.code = bus.byte_data;
    end

    assign fifo_push = new_press || gen_brk;

    kbd_evt_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (EVT_W)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (fifo_push),
        .push_data (push_evt),
        .pop       (bus.evt_ready),
        .head      (bus.evt_data),
        .not_empty (fifo_not_empty),
        .drop      (fifo_drop)
    );

    assign bus.evt_valid = fifo_not_empty;

    // -----------------------------------------------------------------------
    // State registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= IDLE;
            slot_valid   <= '0;
            press_count  <= '0;
            key_code     <= '0;
            key_ext      <= 1'b0;
            evt_overflow <= 1'b0;
        end else begin
            state <= state_nxt;
            if (new_press) begin
                press_count <= press_count + 1'b1;
                key_code    <= bus.byte_data;
                key_ext     <= gen_ext;
            end
            if (fifo_drop) evt_overflow <= 1'b1;
            for (int i = 0; i < HELD_DEPTH; i++) begin
                if (new_press && free_onehot[i])
                    slot_valid[i] <= 1'b1;
                else if (gen_brk && slot_hit[i])
                    slot_valid[i] <= 1'b0;
            end
        end
    end

    // Key storage qualified by slot_valid, so it needs no reset.
    always_ff @(posedge clk) begin
        for (int i = 0; i < HELD_DEPTH; i++) begin
            if (new_press && free_onehot[i]) slot_key[i] <= cur_key;
        end
    end

    // -----------------------------------------------------------------------
    // Displays
    // -----------------------------------------------------------------------
    logic [7:0] key_hi_seg;
    logic [7:0] key_lo_seg;

    assign is_press = |slot_valid;

    hex7seg u_key_hi (.nibble(key_code[7:4]), .seg(key_hi_seg));
    hex7seg u_key_lo (.nibble(key_code[3:0]), .seg(key_lo_seg));

    // Blank after decoding so key_code itself survives the release.
    assign key_seg = is_press ? {key_hi_seg, key_lo_seg} : {BLANK_SEG, BLANK_SEG};

    for (genvar d = 0; d < DIGITS; d++) begin : g_cnt_digit
        hex7seg u_digit (
            .nibble (press_count[4*d +: 4]),
            .seg    (count_seg[8*d +: 8])
        );
    end

endmodule

// File: tb/tb_kbd_event_tracker.sv
// ---------------------------------------------------------------------------
// tb_kbd_event_tracker
// Self-checking bench for kbd_event_tracker. A key-level reference model
// (held-key queue, expected-event queue, press counter) is updated for every
// make/break issued; DUT outputs are compared on the falling clock edge.
// ---------------------------------------------------------------------------
module tb_kbd_event_tracker;

    localparam int HELD_DEPTH = 4;
    localparam int FIFO_DEPTH = 8;
    localparam int CNT_W      = 8;

    logic                 clk = 1'b0;
    logic                 rst = 1'b0;
    logic                 evt_overflow;
    logic [7:0]           key_code;
    logic                 key_ext;
    logic                 is_press;
    logic [CNT_W-1:0]     press_count;
    logic [15:0]          key_seg;
    logic [2*CNT_W-1:0]   count_seg;

    kbd_event_tracker_if bus ();

    kbd_event_tracker #(
        .HELD_DEPTH (HELD_DEPTH),
        .FIFO_DEPTH (FIFO_DEPTH),
        .CNT_W      (CNT_W)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .bus          (bus),
        .evt_overflow (evt_overflow),
        .key_code     (key_code),
        .key_ext      (key_ext),
        .is_press     (is_press),
        .press_count  (press_count),
        .key_seg      (key_seg),
        .count_seg    (count_seg)
    );

    always #5 clk = ~clk;

    int tests_run    = 0;
    int tests_failed = 0;

    // ---------------- reference model ----------------
    logic [8:0]       held_q [$];   // {ext, code} of keys currently held
    logic [9:0]       exp_q  [$];   // events the consumer should see
    logic [CNT_W-1:0] m_count;
    logic [7:0]       m_code;
    logic             m_ext;
    logic             m_ovf;

    function automatic logic [7:0] seg7(input logic [3:0] n);
        logic [7:0] t [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                               8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};
        return t[n];
    endfunction

    function automatic logic [15:0] exp_key_seg();
        if (held_q.size() == 0) return 16'hFFFF;
        return {seg7(m_code[7:4]), seg7(m_code[3:0])};
    endfunction

    function automatic logic [2*CNT_W-1:0] exp_count_seg();
        logic [2*CNT_W-1:0] s;
        for (int d = 0; d < CNT_W / 4; d++) s[8*d +: 8] = seg7(m_count[4*d +: 4]);
        return s;
    endfunction

    function automatic int held_find(input logic [8:0] k);
        for (int i = 0; i < held_q.size(); i++)
            if (held_q[i] === k) return i;
        return -1;
    endfunction

    function automatic void model_push(input logic [9:0] e);
        if (exp_q.size() >= FIFO_DEPTH) m_ovf = 1'b1;
        else exp_q.push_back(e);
    endfunction

    function automatic void model_make(input logic ext, input logic [7:0] code);
        if (held_find({ext, code}) >= 0) return;
        if (held_q.size() < HELD_DEPTH) held_q.push_back({ext, code});
        m_count = m_count + 1'b1;
        m_code  = code;
        m_ext   = ext;
        model_push({ext, 1'b0, code});
    endfunction

    function automatic void model_break(input logic ext, input logic [7:0] code);
        int idx;
        idx = held_find({ext, code});
        if (idx >= 0) held_q.delete(idx);
        model_push({ext, 1'b1, code});
    endfunction

    function automatic void model_clear();
        held_q.delete();
        exp_q.delete();
        m_count = '0;
        m_code  = '0;
        m_ext   = 1'b0;
        m_ovf   = 1'b0;
    endfunction

    // ---------------- stimulus primitives (entered and left at negedge) ----
    task automatic send_byte(input logic [7:0] b);
        bus.byte_valid = 1'b1;
        bus.byte_data  = b;
        @(negedge clk);
        bus.byte_valid = 1'b0;
    endtask

    task automatic press(input logic ext, input logic [7:0] code);
        if (ext) send_byte(8'hE0);
        send_byte(code);
        model_make(ext, code);
    endtask

    task automatic release_key(input logic ext, input logic [7:0] code);
        if (ext) send_byte(8'hE0);
        send_byte(8'hF0);
        send_byte(code);
        model_break(ext, code);
    endtask

    task automatic do_reset();
        rst = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        model_clear();
    endtask

    // Take one event from the DUT and compare it with the model's next one.
    task automatic pop_check(input string name);
        logic [9:0] want;
        int         waited;
        want   = exp_q.pop_front();
        waited = 0;
        while (!bus.evt_valid && waited < 16) begin
            @(negedge clk);
            waited++;
        end
        tests_run++;
        if (!bus.evt_valid) begin
            tests_failed++;
            $display("FAIL %s: no event within 16 cycles, expected %h", name, want);
        end else begin
            if (bus.evt_data !== want) begin
                tests_failed++;
                $display("FAIL %s: event %h, expected %h", name, bus.evt_data, want);
            end
            bus.evt_ready = 1'b1;
            @(negedge clk);
            bus.evt_ready = 1'b0;
        end
    endtask

    task automatic drain(input string name);
        while (exp_q.size() > 0) pop_check(name);
        tests_run++;
        if (bus.evt_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL %s: evt_valid %b after all expected events, expected 0", name, bus.evt_valid);
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        do_reset();
        tests_run++;
        if ({bus.evt_valid, is_press, evt_overflow} !== 3'b000) begin
            tests_failed++;
            $display("FAIL reset_flags: {evt_valid,is_press,ovf}=%b, expected 000",
                     {bus.evt_valid, is_press, evt_overflow});
        end
        tests_run++;
        if (key_seg !== 16'hFFFF) begin
            tests_failed++;
            $display("FAIL reset_key_seg: %h, expected ffff", key_seg);
        end
        tests_run++;
        if (count_seg !== exp_count_seg() || press_count !== '0) begin
            tests_failed++;
            $display("FAIL reset_count: count=%h seg=%h, expected 0 / %h",
                     press_count, count_seg, exp_count_seg());
        end
    endtask

    task automatic test_make_break();
        press(1'b0, 8'h1C);
        tests_run++;
        if (key_seg !== exp_key_seg() || is_press !== 1'b1 || press_count !== m_count) begin
            tests_failed++;
            $display("FAIL make_1c: seg=%h press=%b cnt=%0d, expected %h 1 %0d",
                     key_seg, is_press, press_count, exp_key_seg(), m_count);
        end
        pop_check("make_1c_evt");
        send_byte(8'hF0);
        tests_run++;
        if (is_press !== 1'b1 || bus.evt_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL prefix_f0: is_press=%b evt_valid=%b, expected 1 0", is_press, bus.evt_valid);
        end
        send_byte(8'h1C);
        model_break(1'b0, 8'h1C);
        tests_run++;
        if (is_press !== 1'b0 || key_seg !== 16'hFFFF || key_code !== 8'h1C) begin
            tests_failed++;
            $display("FAIL break_1c: is_press=%b seg=%h code=%h, expected 0 ffff 1c",
                     is_press, key_seg, key_code);
        end
        drain("break_1c_evt");
    endtask

    task automatic test_typematic();
        for (int i = 0; i < 3; i++) press(1'b0, 8'h1C);
        release_key(1'b0, 8'h1C);
        tests_run++;
        if (press_count !== m_count) begin
            tests_failed++;
            $display("FAIL typematic_count: %0d, expected %0d", press_count, m_count);
        end
        drain("typematic_evt");
    endtask

    task automatic test_extended();
        press(1'b1, 8'h75);
        tests_run++;
        if (key_ext !== 1'b1 || key_code !== 8'h75) begin
            tests_failed++;
            $display("FAIL ext_make: ext=%b code=%h, expected 1 75", key_ext, key_code);
        end
        release_key(1'b1, 8'h75);
        drain("ext_evt");
        // Repeated E0 prefix still yields a single extended make.
        send_byte(8'hE0);
        press(1'b1, 8'h6B);
        release_key(1'b1, 8'h6B);
        drain("ext_e0e0_evt");
    endtask

    task automatic test_dropped();
        logic [7:0] resp [4] = '{8'hFA, 8'hAA, 8'h00, 8'hFF};
        for (int i = 0; i < 4; i++) send_byte(resp[i]);
        @(negedge clk);
        tests_run++;
        if (bus.evt_valid !== 1'b0 || press_count !== m_count) begin
            tests_failed++;
            $display("FAIL dropped_bytes: evt_valid=%b cnt=%0d, expected 0 %0d",
                     bus.evt_valid, press_count, m_count);
        end
    endtask

    task automatic test_table_full();
        logic [7:0] keys [5] = '{8'h15, 8'h1D, 8'h24, 8'h2D, 8'h2C};
        for (int i = 0; i < 5; i++) press(1'b0, keys[i]);
        tests_run++;
        if (press_count !== m_count || key_code !== 8'h2C) begin
            tests_failed++;
            $display("FAIL table_full_count: cnt=%0d code=%h, expected %0d 2c",
                     press_count, key_code, m_count);
        end
        press(1'b0, 8'h2C);   // fifth key was not stored: counts again
        press(1'b0, 8'h15);   // held: typematic, nothing
        tests_run++;
        if (press_count !== m_count || is_press !== 1'b1) begin
            tests_failed++;
            $display("FAIL table_full_repeat: cnt=%0d press=%b, expected %0d 1",
                     press_count, is_press, m_count);
        end
        drain("table_full_evt");
        for (int i = 0; i < 5; i++) release_key(1'b0, keys[i]);
        drain("table_full_rel");
        tests_run++;
        if (is_press !== 1'b0) begin
            tests_failed++;
            $display("FAIL table_full_clear: is_press=%b, expected 0", is_press);
        end
    endtask

    task automatic test_overflow();
        logic [9:0] want;
        bus.evt_ready = 1'b0;
        for (int i = 0; i < 9; i++) press(1'b0, 8'h10 + 8'(i));
        tests_run++;
        if (evt_overflow !== m_ovf) begin
            tests_failed++;
            $display("FAIL overflow_flag: %b, expected %b", evt_overflow, m_ovf);
        end
        // Full FIFO, pop and push in the same cycle.
        want = exp_q.pop_front();
        tests_run++;
        if (bus.evt_valid !== 1'b1 || bus.evt_data !== want) begin
            tests_failed++;
            $display("FAIL overflow_head: valid=%b data=%h, expected 1 %h",
                     bus.evt_valid, bus.evt_data, want);
        end
        bus.evt_ready = 1'b1;
        press(1'b0, 8'h19);
        bus.evt_ready = 1'b0;
        drain("overflow_order");
        for (int i = 0; i < 10; i++) begin
            release_key(1'b0, 8'h10 + 8'(i));
            drain("overflow_rel");
        end
    endtask

    task automatic test_random();
        logic [7:0] pool [8] = '{8'h1C, 8'h1B, 8'h23, 8'h2B, 8'h34, 8'h33, 8'h3B, 8'h42};
        logic       ext;
        logic [7:0] code;
        for (int it = 0; it < 300; it++) begin
            ext  = 1'($urandom_range(0, 1));
            code = pool[$urandom_range(0, 7)];
            if ($urandom_range(0, 9) < 6) press(ext, code);
            else release_key(ext, code);
            if ($urandom_range(0, 3) == 0) @(negedge clk);
            tests_run++;
            if (press_count !== m_count || is_press !== (held_q.size() > 0) ||
                key_seg !== exp_key_seg() || count_seg !== exp_count_seg()) begin
                tests_failed++;
                $display("FAIL random_state[%0d]: cnt=%0d press=%b kseg=%h cseg=%h, expected %0d %b %h %h",
                         it, press_count, is_press, key_seg, count_seg,
                         m_count, held_q.size() > 0, exp_key_seg(), exp_count_seg());
            end
            tests_run++;
            if (m_count != '0 && (key_code !== m_code || key_ext !== m_ext)) begin
                tests_failed++;
                $display("FAIL random_key[%0d]: code=%h ext=%b, expected %h %b",
                         it, key_code, key_ext, m_code, m_ext);
            end
            if (exp_q.size() >= FIFO_DEPTH - 2 || $urandom_range(0, 4) == 0) drain("random_evt");
        end
        drain("random_evt_end");
        tests_run++;
        if (evt_overflow !== m_ovf) begin
            tests_failed++;
            $display("FAIL random_ovf: %b, expected %b", evt_overflow, m_ovf);
        end
    endtask

    task automatic test_reset_mid_prefix();
        press(1'b0, 8'h4D);
        send_byte(8'hF0);
        #2 rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        model_clear();
        tests_run++;
        if ({bus.evt_valid, is_press, evt_overflow} !== 3'b000 || press_count !== '0 ||
            key_code !== 8'h00) begin
            tests_failed++;
            $display("FAIL mid_reset_state: flags=%b cnt=%0d code=%h, expected 000 0 00",
                     {bus.evt_valid, is_press, evt_overflow}, press_count, key_code);
        end
        press(1'b0, 8'h1C);
        tests_run++;
        if (press_count !== m_count || is_press !== 1'b1) begin
            tests_failed++;
            $display("FAIL mid_reset_make: cnt=%0d press=%b, expected %0d 1",
                     press_count, is_press, m_count);
        end
        pop_check("mid_reset_evt");
    endtask

    task automatic test_wrap();
        do_reset();
        bus.evt_ready = 1'b1;
        for (int i = 0; i < 256; i++) begin
            press(1'b0, 8'h1C);
            release_key(1'b0, 8'h1C);
            exp_q.delete();
            if (i == 15 || i == 200) begin
                tests_run++;
                if (press_count !== m_count || count_seg !== exp_count_seg()) begin
                    tests_failed++;
                    $display("FAIL wrap_mid[%0d]: cnt=%0d seg=%h, expected %0d %h",
                             i, press_count, count_seg, m_count, exp_count_seg());
                end
            end
        end
        repeat (2) @(negedge clk);
        bus.evt_ready = 1'b0;
        tests_run++;
        if (press_count !== m_count || count_seg !== exp_count_seg() ||
            is_press !== 1'b0 || bus.evt_valid !== 1'b0 || evt_overflow !== 1'b0) begin
            tests_failed++;
            $display("FAIL wrap_end: cnt=%0d seg=%h press=%b valid=%b ovf=%b, expected %0d %h 0 0 0",
                     press_count, count_seg, is_press, bus.evt_valid, evt_overflow,
                     m_count, exp_count_seg());
        end
    endtask

    initial begin
        bus.byte_valid = 1'b0;
        bus.byte_data  = '0;
        bus.evt_ready  = 1'b0;
        model_clear();
        @(negedge clk);
        test_reset();
        test_make_break();
        test_typematic();
        test_extended();
        test_dropped();
        test_table_full();
        test_overflow();
        test_random();
        test_reset_mid_prefix();
        test_wrap();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
